irq_step_sequencer: RTL and testbench

Parametrised successor to the SM83 opcode step sequencer. It owns the instruction register, the per-opcode step counter, CB-prefix latching and conditional-branch step override, as the original did. It adds interrupt dispatch with priority encoding, IME with one-instruction EI delay, and HALT/wake. It sits between the memory data bus and the opcode decoder; the decoder consumes `ir`, `in_prefix`, `in_irq` and `step`, and drives `done`, `is_cond`, `next_cond`, `halt_req`, `ei_req` and `di_req` back.

---
 rtl/irq_step_sequencer_if.sv | 64 ++++++
 rtl/irq_step_sequencer.sv | 261 ++++++++++++++++++++++++++
 tb/tb_irq_step_sequencer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_step_sequencer_if.sv
// -----------------------------------------------------------------------------
// irq_step_sequencer_if
// Bundles the decoder handshake, memory data bus and interrupt lines that
// connect the step sequencer to the rest of the CPU core.
//
// Parameters:
//   STEP_W   width of the step counter
//   NUM_IRQ  number of interrupt sources (index 0 = highest priority)
//
// Signals (direction seen from the sequencer):
//   in : done, is_cond, cond[1:0], flags[3:0] {z,n,h,c}, next_cond,
//        d_in[7:0], halt_req, ei_req, di_req, irq_pending[NUM_IRQ-1:0]
//   out: ir[7:0], in_prefix, in_irq, irq_idx, irq_ack[NUM_IRQ-1:0],
//        step, halted, ime, seq_err
//
// Modports:
//   master  decoder / memory / interrupt-controller side
//   slave   the step sequencer itself
// -----------------------------------------------------------------------------
interface irq_step_sequencer_if #(
   parameter int STEP_W  = 3,
   parameter int NUM_IRQ = 5
) ();

   localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

   // decoder -> sequencer
   logic               done;
   logic               is_cond;
   logic [1:0]         cond;
   logic [3:0]         flags;
   logic [STEP_W-1:0]  next_cond;
   logic               halt_req;
   logic               ei_req;
   logic               di_req;

   // memory bus and interrupt controller -> sequencer
   logic [7:0]         d_in;
   logic [NUM_IRQ-1:0] irq_pending;

   // sequencer -> decoder / interrupt controller
   logic [7:0]         ir;
   logic               in_prefix;
   logic               in_irq;
   logic [IDX_W-1:0]   irq_idx;
   logic [NUM_IRQ-1:0] irq_ack;
   logic [STEP_W-1:0]  step;
   logic               halted;
   logic               ime;
   logic               seq_err;

   modport master (
      output done, is_cond, cond, flags, next_cond, halt_req, ei_req, di_req,
      output d_in, irq_pending,
      input  ir, in_prefix, in_irq, irq_idx, irq_ack, step, halted, ime, seq_err
   );

   modport slave (
      input  done, is_cond, cond, flags, next_cond, halt_req, ei_req, di_req,
      input  d_in, irq_pending,
      output ir, in_prefix, in_irq, irq_idx, irq_ack, step, halted, ime, seq_err
   );

endinterface

// File: rtl/irq_step_sequencer.sv
// -----------------------------------------------------------------------------
// irq_step_sequencer
// Opcode step sequencer for an SM83-style core. Holds the instruction
// register and per-opcode step counter, latches the CB prefix page, applies
// the conditional-branch step override, and adds interrupt dispatch
// (fixed-priority, lowest index wins), IME with a one-instruction EI delay,
// and HALT with wake on any pending interrupt.
//
// Ports:
//   clk   clock
//   rst   synchronous, active-low reset
//   bus   irq_step_sequencer_if.slave (decoder handshake, d_in, irq lines,
//         and all registered sequencer outputs)
//
// Parameters:
//   STEP_W     step counter width; the last legal step is 2^STEP_W-1
//   NUM_IRQ    interrupt sources
//   IRQ_STEPS  cycles spent in the dispatch micro-sequence (2..2^STEP_W)
//   PREFIX_OP  opcode that selects the prefixed page
// -----------------------------------------------------------------------------
module irq_step_sequencer #(
   parameter int         STEP_W    = 3,
   parameter int         NUM_IRQ   = 5,
   parameter int         IRQ_STEPS = 5,
   parameter logic [7:0] PREFIX_OP = 8'hCB
) (
   input logic                 clk,
   input logic                 rst,
   irq_step_sequencer_if.slave bus
);

   localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

   localparam logic [STEP_W-1:0] STEP_MAX = {STEP_W{1'b1}};
   localparam logic [STEP_W-1:0] IRQ_LAST = STEP_W'(IRQ_STEPS - 1);
   localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_HALT = 2'd1,
      ST_IRQ  = 2'd2
   } state_e;

   // ---------------------------------------------------------------------
   // Helpers
   // ---------------------------------------------------------------------

   // Branch condition test: NZ, Z, NC, C.
   function automatic logic cond_match(input logic [1:0] c_sel,
                                       input logic       z_f,
                                       input logic       c_f);
      logic m;
      case (c_sel)
         2'd0:    m = ~z_f;
         2'd1:    m = z_f;
         2'd2:    m = ~c_f;
         2'd3:    m = c_f;
         default: m = 1'b0;
      endcase
      return m;
   endfunction

   // Index of the lowest set bit; scanning downwards lets the lowest win.
   function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_IRQ-1:0] p);
      logic [IDX_W-1:0] r;
      r = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (p[i]) begin
            r = IDX_W'(i);
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

   // One-hot decode of a source index.
   function automatic logic [NUM_IRQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
      logic [NUM_IRQ-1:0] r;
      for (int i = 0; i < NUM_IRQ; i++) begin
         r[i] = (IDX_W'(i) == idx);
      end
      return r;
   endfunction

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   state_e             state_q,       state_d;
   logic [7:0]         ir_q,          ir_d;
   logic [STEP_W-1:0]  step_q,        step_d;
   logic               in_prefix_q,   in_prefix_d;
   logic               in_irq_q,      in_irq_d;
   logic [IDX_W-1:0]   irq_idx_q,     irq_idx_d;
   logic [NUM_IRQ-1:0] irq_ack_q,     irq_ack_d;
   logic               halted_q,      halted_d;
   logic               ime_q,         ime_d;
   logic               ime_pending_q, ime_pending_d;
   logic               seq_err_q,     seq_err_d;

   logic               irq_any_s;
   logic               ime_eff_s;
   logic               take_irq_s;
   logic [IDX_W-1:0]   irq_sel_s;
   logic               flags_nh_unused;

   assign irq_any_s = |bus.irq_pending;
   assign irq_sel_s = lowest_idx(bus.irq_pending);
   // A DI finishing this very cycle masks dispatch at its own done.
   assign ime_eff_s = (ime_q | ime_pending_q) & ~(bus.done & bus.di_req);
   // n and h do not take part in any branch condition.
   assign flags_nh_unused = ^bus.flags[2:1];

   // Decide whether an interrupt dispatch starts on this edge.
   always_comb begin
      take_irq_s = 1'b0;
      case (state_q)
         ST_RUN:  take_irq_s = bus.done & ime_eff_s & irq_any_s;
         ST_HALT: take_irq_s = irq_any_s & ime_q;
         ST_IRQ:  take_irq_s = 1'b0;
         default: take_irq_s = 1'b0;
      endcase
   end

   // Next-state and next-output computation for the sequencer FSM.
   always_comb begin
      state_d       = state_q;
      ir_d          = ir_q;
      step_d        = step_q;
      in_prefix_d   = in_prefix_q;
      in_irq_d      = in_irq_q;
      irq_idx_d     = irq_idx_q;
      irq_ack_d     = '0;
      halted_d      = halted_q;
      ime_d         = ime_q;
      ime_pending_d = ime_pending_q;
      seq_err_d     = seq_err_q;

      if (take_irq_s) begin
         // Dispatch entry; ir keeps the interrupted opcode until the
         // vector opcode is fetched at the end of the micro-sequence.
         state_d       = ST_IRQ;
         in_irq_d      = 1'b1;
         halted_d      = 1'b0;
         step_d        = '0;
         in_prefix_d   = 1'b0;
         irq_idx_d     = irq_sel_s;
         irq_ack_d     = idx_onehot(irq_sel_s);
         ime_d         = 1'b0;
         ime_pending_d = 1'b0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (bus.done) begin
                  // A pending interrupt with IME off cancels HALT and the
                  // next opcode is fetched normally.
                  if (bus.halt_req && !irq_any_s) begin
                     state_d  = ST_HALT;
                     halted_d = 1'b1;
                     step_d   = '0;
                  end else begin
                     ir_d        = bus.d_in;
                     step_d      = '0;
                     in_prefix_d = 1'b0;
                  end
                  // DI clears, otherwise a delayed EI is promoted.
                  if (bus.di_req) begin
                     ime_d = 1'b0;
                  end else if (ime_pending_q) begin
                     ime_d = 1'b1;
                  end else begin
                     ime_d = ime_q;
                  end
                  // Any earlier pending flag is consumed above, so only a
                  // new EI leaves it set.
                  ime_pending_d = bus.ei_req;
               end else if ((step_q == '0) && (ir_q == PREFIX_OP) && !in_prefix_q) begin
                  ir_d        = bus.d_in;
                  in_prefix_d = 1'b1;
               end else if (bus.is_cond &&
                            !cond_match(bus.cond, bus.flags[3], bus.flags[0])) begin
                  step_d = bus.next_cond;
               end else if (step_q == STEP_MAX) begin
                  seq_err_d = 1'b1;
               end else begin
                  step_d = step_q + STEP_ONE;
               end
            end

            ST_HALT: begin
               if (irq_any_s) begin
                  state_d  = ST_RUN;
                  halted_d = 1'b0;
                  ir_d     = bus.d_in;
                  step_d   = '0;
               end else begin
                  step_d = '0;
               end
            end

            ST_IRQ: begin
               if (step_q == IRQ_LAST) begin
                  state_d  = ST_RUN;
                  in_irq_d = 1'b0;
                  ir_d     = bus.d_in;
                  step_d   = '0;
               end else begin
                  step_d = step_q + STEP_ONE;
               end
            end

            default: begin
               state_d  = ST_RUN;
               halted_d = 1'b0;
               in_irq_d = 1'b0;
               step_d   = '0;
            end
         endcase
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= ST_RUN;
         ir_q          <= 8'h00;
         step_q        <= '0;
         in_prefix_q   <= 1'b0;
         in_irq_q      <= 1'b0;
         irq_idx_q     <= '0;
         irq_ack_q     <= '0;
         halted_q      <= 1'b0;
         ime_q         <= 1'b0;
         ime_pending_q <= 1'b0;
         seq_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         ir_q          <= ir_d;
         step_q        <= step_d;
         in_prefix_q   <= in_prefix_d;
         in_irq_q      <= in_irq_d;
         irq_idx_q     <= irq_idx_d;
         irq_ack_q     <= irq_ack_d;
         halted_q      <= halted_d;
         ime_q         <= ime_d;
         ime_pending_q <= ime_pending_d;
         seq_err_q     <= seq_err_d;
      end
   end

   assign bus.ir        = ir_q;
   assign bus.step      = step_q;
   assign bus.in_prefix = in_prefix_q;
   assign bus.in_irq    = in_irq_q;
   assign bus.irq_idx   = irq_idx_q;
   assign bus.irq_ack   = irq_ack_q;
   assign bus.halted    = halted_q;
   assign bus.ime       = ime_q;
   assign bus.seq_err   = seq_err_q;

endmodule

// File: tb/tb_irq_step_sequencer.sv
// -----------------------------------------------------------------------------
// tb_irq_step_sequencer
// Directed walk through the sequencer's main behaviours followed by a
// randomized phase. A behavioural model written from the sequencing rules
// predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_irq_step_sequencer;

   localparam int         STEP_W    = 3;
   localparam int         NUM_IRQ   = 5;
   localparam int         IRQ_STEPS = 5;
   localparam logic [7:0] PREFIX_OP = 8'hCB;
   localparam int         STEP_MAX  = (1 << STEP_W) - 1;

   logic clk;
   logic rst;

   irq_step_sequencer_if #(.STEP_W(STEP_W), .NUM_IRQ(NUM_IRQ)) bus ();

   irq_step_sequencer #(
      .STEP_W   (STEP_W),
      .NUM_IRQ  (NUM_IRQ),
      .IRQ_STEPS(IRQ_STEPS),
      .PREFIX_OP(PREFIX_OP)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int m_ir, m_step, m_idx, m_ack;
   bit m_prefix, m_in_irq, m_halted, m_ime, m_pend, m_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit cond_ok(input int c, input bit z, input bit cy);
      if (c == 0) return !z;
      if (c == 1) return z;
      if (c == 2) return !cy;
      return cy;
   endfunction

   task automatic model_take(input int p);
      int idx;
      idx = 0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (p[i]) begin
            idx = i;
            break;
         end
      end
      m_idx    = idx;
      m_ack    = 1 << idx;
      m_in_irq = 1;
      m_halted = 0;
      m_step   = 0;
      m_prefix = 0;
      m_ime    = 0;
      m_pend   = 0;
   endtask

   // Advance the model by one clock using the inputs currently applied.
   task automatic model_clock();
      int p;
      bit eff;
      p     = int'(bus.irq_pending);
      m_ack = 0;
      if (!rst) begin
         m_ir = 0; m_step = 0; m_idx = 0; m_prefix = 0; m_in_irq = 0;
         m_halted = 0; m_ime = 0; m_pend = 0; m_err = 0;
      end else if (m_in_irq) begin
         if (m_step == IRQ_STEPS - 1) begin
            m_ir = int'(bus.d_in); m_in_irq = 0; m_step = 0;
         end else begin
            m_step = m_step + 1;
         end
      end else if (m_halted) begin
         if (p != 0) begin
            if (m_ime) model_take(p);
            else begin
               m_halted = 0; m_ir = int'(bus.d_in); m_step = 0;
            end
         end
      end else if (bus.done) begin
         eff = (m_ime || m_pend) && !bus.di_req;
         if (eff && p != 0) begin
            model_take(p);
         end else begin
            if (bus.halt_req && p == 0) begin
               m_halted = 1; m_step = 0;
            end else begin
               m_ir = int'(bus.d_in); m_step = 0; m_prefix = 0;
            end
            if (bus.di_req) begin
               m_ime = 0; m_pend = 0;
            end else if (m_pend) begin
               m_ime = 1; m_pend = 0;
            end
            if (bus.ei_req) m_pend = 1;
         end
      end else begin
         if (m_step == 0 && m_ir == int'(PREFIX_OP) && !m_prefix) begin
            m_ir = int'(bus.d_in); m_prefix = 1;
         end else if (bus.is_cond && !cond_ok(int'(bus.cond), bus.flags[3], bus.flags[0])) begin
            m_step = int'(bus.next_cond);
         end else if (m_step == STEP_MAX) begin
            m_err = 1;
         end else begin
            m_step = m_step + 1;
         end
      end
   endtask

   task automatic compare_all();
      check("ir",        32'(bus.ir),        32'(m_ir));
      check("step",      32'(bus.step),      32'(m_step));
      check("in_prefix", 32'(bus.in_prefix), 32'(m_prefix));
      check("in_irq",    32'(bus.in_irq),    32'(m_in_irq));
      check("irq_idx",   32'(bus.irq_idx),   32'(m_idx));
      check("irq_ack",   32'(bus.irq_ack),   32'(m_ack));
      check("halted",    32'(bus.halted),    32'(m_halted));
      check("ime",       32'(bus.ime),       32'(m_ime));
      check("seq_err",   32'(bus.seq_err),   32'(m_err));
   endtask

   task automatic tick();
      @(posedge clk);
      model_clock();
      #1;
      compare_all();
   endtask

   task automatic idle();
      bus.done = 1'b0; bus.is_cond = 1'b0; bus.cond = 2'd0; bus.flags = 4'h0;
      bus.next_cond = '0; bus.halt_req = 1'b0; bus.ei_req = 1'b0; bus.di_req = 1'b0;
   endtask

   initial begin
      logic [31:0] r;
      rst = 1'b0;
      idle();
      bus.d_in = 8'h00;
      bus.irq_pending = '0;
      m_ir = 0; m_step = 0; m_idx = 0; m_ack = 0; m_prefix = 0; m_in_irq = 0;
      m_halted = 0; m_ime = 0; m_pend = 0; m_err = 0;

      // Reset
      tick(); tick();
      check("rst_ir", 32'(bus.ir), 32'h00);
      check("rst_step", 32'(bus.step), 32'd0);
      check("rst_ack", 32'(bus.irq_ack), 32'd0);

      // Plain fetch and stepping
      rst = 1'b1; bus.done = 1'b1; bus.d_in = 8'h00; tick();
      check("fetch00_ir", 32'(bus.ir), 32'h00);
      bus.d_in = 8'h3E; tick();
      check("fetch3e_ir", 32'(bus.ir), 32'h3E);
      bus.done = 1'b0; tick();
      check("step1", 32'(bus.step), 32'd1);
      tick();
      check("step2", 32'(bus.step), 32'd2);

      // CB prefix latch
      bus.done = 1'b1; bus.d_in = 8'hCB; tick();
      bus.done = 1'b0; bus.d_in = 8'h11; tick();
      check("pfx_ir", 32'(bus.ir), 32'h11);
      check("pfx_flag", 32'(bus.in_prefix), 32'd1);
      check("pfx_step", 32'(bus.step), 32'd0);
      bus.done = 1'b1; bus.d_in = 8'h00; tick();
      check("pfx_clear", 32'(bus.in_prefix), 32'd0);

      // Conditional branch override
      bus.done = 1'b0; bus.is_cond = 1'b1; bus.cond = 2'd1; bus.flags = 4'b0000;
      bus.next_cond = 3'd3; tick();
      check("jr_unmatched", 32'(bus.step), 32'd3);
      bus.is_cond = 1'b0; bus.done = 1'b1; bus.d_in = 8'h20; tick();
      bus.done = 1'b0; bus.is_cond = 1'b1; bus.flags = 4'b1000; tick();
      check("jr_matched", 32'(bus.step), 32'd1);
      idle();

      // Enable IME, then dispatch with two sources pending
      bus.done = 1'b1; bus.ei_req = 1'b1; bus.d_in = 8'h00; tick();
      bus.ei_req = 1'b0; tick();
      check("ime_on", 32'(bus.ime), 32'd1);
      bus.irq_pending = 5'b10100; bus.d_in = 8'h55; tick();
      check("irq_in", 32'(bus.in_irq), 32'd1);
      check("irq_idx2", 32'(bus.irq_idx), 32'd2);
      check("irq_ack", 32'(bus.irq_ack), 32'b00100);
      check("irq_ime", 32'(bus.ime), 32'd0);
      check("irq_ir_kept", 32'(bus.ir), 32'h00);
      bus.irq_pending = 5'b00001; bus.di_req = 1'b1; bus.d_in = 8'hC3; tick();
      check("ack_pulse", 32'(bus.irq_ack), 32'd0);
      check("idx_held", 32'(bus.irq_idx), 32'd2);
      tick(); tick();
      bus.done = 1'b0; bus.di_req = 1'b0; tick();
      check("irq_step4", 32'(bus.step), 32'd4);
      tick();
      check("irq_end_ir", 32'(bus.ir), 32'hC3);
      check("irq_end", 32'(bus.in_irq), 32'd0);

      // EI delay: no dispatch at EI's own done
      bus.done = 1'b1; bus.ei_req = 1'b1; bus.d_in = 8'h00; tick();
      check("ei_nodisp", 32'(bus.in_irq), 32'd0);
      bus.done = 1'b0; bus.ei_req = 1'b0; tick();
      bus.done = 1'b1; tick();
      check("ei_disp", 32'(bus.in_irq), 32'd1);
      check("ei_idx0", 32'(bus.irq_idx), 32'd0);
      bus.done = 1'b0;
      for (int i = 0; i < IRQ_STEPS; i++) tick();

      // DI blocks dispatch at its own done
      bus.irq_pending = '0; bus.done = 1'b1; bus.ei_req = 1'b1; tick();
      bus.ei_req = 1'b0; tick();
      bus.irq_pending = 5'b00001; bus.di_req = 1'b1; tick();
      check("di_nodisp", 32'(bus.in_irq), 32'd0);
      check("di_ime", 32'(bus.ime), 32'd0);
      idle();

      // HALT requested with an interrupt pending and IME off: fetch instead
      bus.irq_pending = 5'b00010; bus.done = 1'b1; bus.halt_req = 1'b1; bus.d_in = 8'h46; tick();
      check("halt_bug_halted", 32'(bus.halted), 32'd0);
      check("halt_bug_ir", 32'(bus.ir), 32'h46);

      // HALT, wake with IME off
      bus.irq_pending = '0; bus.d_in = 8'h99; tick();
      check("halt_on", 32'(bus.halted), 32'd1);
      idle(); tick();
      check("halt_hold_ir", 32'(bus.ir), 32'h46);
      bus.irq_pending = 5'b01000; bus.d_in = 8'h77; tick();
      check("wake_halted", 32'(bus.halted), 32'd0);
      check("wake_ir", 32'(bus.ir), 32'h77);
      check("wake_noack", 32'(bus.irq_ack), 32'd0);
      bus.irq_pending = '0;

      // HALT, wake with IME on
      bus.done = 1'b1; bus.ei_req = 1'b1; tick();
      bus.ei_req = 1'b0; tick();
      bus.halt_req = 1'b1; tick();
      idle(); bus.irq_pending = 5'b01000; tick();
      check("wake_irq", 32'(bus.in_irq), 32'd1);
      check("wake_idx3", 32'(bus.irq_idx), 32'd3);
      bus.irq_pending = '0; bus.d_in = 8'h00;
      for (int i = 0; i < IRQ_STEPS; i++) tick();

      // Step overflow without done
      for (int i = 0; i < STEP_MAX + 1; i++) tick();
      check("seq_err", 32'(bus.seq_err), 32'd1);
      check("seq_step", 32'(bus.step), 32'(STEP_MAX));

      // Reset while halted
      bus.done = 1'b1; bus.halt_req = 1'b1; tick();
      idle(); rst = 1'b0; tick();
      check("rst_halt", 32'(bus.halted), 32'd0);
      check("rst_err", 32'(bus.seq_err), 32'd0);
      rst = 1'b1;

      // Randomized phase
      for (int n = 0; n < 2000; n++) begin
         r = $urandom;
         rst           = ($urandom_range(199) != 0);
         bus.done      = ($urandom_range(3) == 0);
         bus.is_cond   = ($urandom_range(3) == 0);
         bus.cond      = r[1:0];
         bus.flags     = r[5:2];
         bus.next_cond = r[8:6];
         bus.d_in      = ($urandom_range(7) == 0) ? PREFIX_OP : r[16:9];
         bus.halt_req  = ($urandom_range(15) == 0);
         bus.ei_req    = ($urandom_range(7) == 0);
         bus.di_req    = ($urandom_range(7) == 0);
         bus.irq_pending = ($urandom_range(7) == 0) ? r[21:17] : 5'b00000;
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
